ps2_mouse_rx: RTL and testbench

- Receive-side PS/2 mouse decoder, sitting between the PS/2 pins and the oscilloscope user interface.
- Deserializes device-to-host PS/2 frames and assembles standard 3-byte stream-mode movement packets.
- Integrates the signed X/Y deltas into absolute, screen-clamped cursor coordinates and publishes them with button levels. These are the xpos/ypos/left/right/middle inputs of the UI logic.
- Mouse initialization (host-to-device 0xF4) is owned by a separate block; this block only listens.

---
 rtl/ps2_mouse_rx.sv | 226 ++++++++++++++++++++++
 tb/tb_ps2_mouse_rx.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_mouse_rx.sv
// ps2_mouse_rx
// Receive-only PS/2 mouse decoder. It deserializes device-to-host frames,
// assembles 3-byte stream-mode movement packets and integrates the signed
// X/Y deltas into absolute cursor coordinates, clamped to the screen.
// Mouse initialization (host-to-device 0xF4) is handled elsewhere; this
// block only listens.
//
// Optional feature macro: PS2_PARITY_CHECK_EN
//   defined     : STOP also requires odd parity over the 8 data bits plus
//                 the parity bit; a mismatch discards the byte.
//   not defined : the parity bit is ignored.
//
// Ports:
//   i_clk            system clock
//   i_rst_n          asynchronous active-low reset
//   i_ps2_clk        raw PS/2 clock pin (asynchronous)
//   i_ps2_data       raw PS/2 data pin (asynchronous)
//   o_xpos           absolute cursor X, 0..X_MAX
//   o_ypos           absolute cursor Y, 0..Y_MAX, 0 = top
//   o_left           left button level
//   o_right          right button level
//   o_middle         middle button level
//   o_pkt_valid      1-cycle strobe, outputs updated from a new packet
//   o_frame_err      1-cycle strobe, frame or packet discarded
//   o_dbg_state      frame FSM state (0 IDLE, 1 DATA, 2 PARITY, 3 STOP)
//   o_dbg_byte_idx   index of the next packet byte (0..2)

module ps2_mouse_rx #(
  parameter int X_MAX          = 1023,
  parameter int Y_MAX          = 767,
  parameter int TIMEOUT_CYCLES = 2_000_000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_ps2_clk,
  input  logic        i_ps2_data,
  output logic [11:0] o_xpos,
  output logic [11:0] o_ypos,
  output logic        o_left,
  output logic        o_right,
  output logic        o_middle,
  output logic        o_pkt_valid,
  output logic        o_frame_err,
  output logic [1:0]  o_dbg_state,
  output logic [1:0]  o_dbg_byte_idx
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_STOP   = 2'd3;

  localparam int               TO_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0]  TO_LIMIT = TO_W'(TIMEOUT_CYCLES);

  localparam logic signed [13:0] LP_XMAX  = 14'(X_MAX);
  localparam logic signed [13:0] LP_YMAX  = 14'(Y_MAX);
  localparam logic [11:0]        X_RESET  = 12'((X_MAX + 1) / 2);
  localparam logic [11:0]        Y_RESET  = 12'((Y_MAX + 1) / 2);

  // Synchronizers and edge detect
  logic r_clk_s1, r_clk_s2, r_clk_d;
  logic r_dat_s1, r_dat_s2;
  logic r_fall;   // registered falling edge of the synchronized PS/2 clock
  logic r_bit;    // data bit aligned with r_fall

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_clk_s1 <= 1'b1;
      r_clk_s2 <= 1'b1;
      r_clk_d  <= 1'b1;
      r_dat_s1 <= 1'b1;
      r_dat_s2 <= 1'b1;
      r_fall   <= 1'b0;
      r_bit    <= 1'b1;
    end else begin
      r_clk_s1 <= i_ps2_clk;
      r_clk_s2 <= r_clk_s1;
      r_clk_d  <= r_clk_s2;
      r_dat_s1 <= i_ps2_data;
      r_dat_s2 <= r_dat_s1;
      r_fall   <= r_clk_d & ~r_clk_s2;
      r_bit    <= r_dat_s2;
    end
  end

  // Frame / packet state
  logic [1:0]      r_state;
  logic [2:0]      r_bit_cnt;
  logic [7:0]      r_shift;
  logic [1:0]      r_byte_idx;
  logic [TO_W-1:0] r_to_cnt;
  logic [2:0]      r_btn;      // {M, R, L} from byte 0
  logic            r_xs, r_ys, r_xo, r_yo;
  logic [7:0]      r_b1;

  logic w_parity_ok;
`ifdef PS2_PARITY_CHECK_EN
  logic r_par;
  // Odd parity: data bits plus parity bit must contain an odd number of ones.
  assign w_parity_ok = ^{r_shift, r_par};
`else
  assign w_parity_ok = 1'b1;
`endif

  // Packet commit arithmetic. Byte 2 is still in r_shift when STOP is seen.
  logic signed [13:0] w_dx, w_dy, w_xn, w_yn;
  logic [11:0]        w_xc, w_yc;

  always_comb begin
    w_dx = r_xo ? 14'sd0 : $signed({{6{r_xs}}, r_b1});
    w_dy = r_yo ? 14'sd0 : $signed({{6{r_ys}}, r_shift});
    w_xn = $signed({2'b00, o_xpos}) + w_dx;
    // PS/2 +Y is up, screen Y grows downward.
    w_yn = $signed({2'b00, o_ypos}) - w_dy;
    w_xc = w_xn[11:0];
    w_yc = w_yn[11:0];
    if (w_xn < 14'sd0)        w_xc = 12'd0;
    else if (w_xn > LP_XMAX)  w_xc = 12'(X_MAX);
    if (w_yn < 14'sd0)        w_yc = 12'd0;
    else if (w_yn > LP_YMAX)  w_yc = 12'(Y_MAX);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_bit_cnt   <= 3'd0;
      r_shift     <= 8'd0;
      r_byte_idx  <= 2'd0;
      r_to_cnt    <= '0;
      r_btn       <= 3'd0;
      r_xs        <= 1'b0;
      r_ys        <= 1'b0;
      r_xo        <= 1'b0;
      r_yo        <= 1'b0;
      r_b1        <= 8'd0;
`ifdef PS2_PARITY_CHECK_EN
      r_par       <= 1'b0;
`endif
      o_xpos      <= X_RESET;
      o_ypos      <= Y_RESET;
      o_left      <= 1'b0;
      o_right     <= 1'b0;
      o_middle    <= 1'b0;
      o_pkt_valid <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      o_pkt_valid <= 1'b0;
      o_frame_err <= 1'b0;
      if (r_fall) begin
        // An edge always wins over a coincident timeout.
        r_to_cnt <= '0;
        case (r_state)
          ST_IDLE: begin
            if (!r_bit) begin
              r_state   <= ST_DATA;
              r_bit_cnt <= 3'd0;
            end
          end
          ST_DATA: begin
            r_shift   <= {r_bit, r_shift[7:1]};   // LSB first
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) r_state <= ST_PARITY;
          end
          ST_PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
            r_par   <= r_bit;
`endif
            r_state <= ST_STOP;
          end
          default: begin  // ST_STOP
            r_state <= ST_IDLE;
            if (!r_bit || !w_parity_ok) begin
              o_frame_err <= 1'b1;
              r_byte_idx  <= 2'd0;
            end else begin
              case (r_byte_idx)
                2'd0: begin
                  // Bit 3 is always set in a header byte; anything else
                  // means we are out of step with the packet stream.
                  if (!r_shift[3]) begin
                    o_frame_err <= 1'b1;
                  end else begin
                    r_btn      <= r_shift[2:0];
                    r_xs       <= r_shift[4];
                    r_ys       <= r_shift[5];
                    r_xo       <= r_shift[6];
                    r_yo       <= r_shift[7];
                    r_byte_idx <= 2'd1;
                  end
                end
                2'd1: begin
                  r_b1       <= r_shift;
                  r_byte_idx <= 2'd2;
                end
                2'd2: begin
                  o_xpos      <= w_xc;
                  o_ypos      <= w_yc;
                  o_left      <= r_btn[0];
                  o_right     <= r_btn[1];
                  o_middle    <= r_btn[2];
                  o_pkt_valid <= 1'b1;
                  r_byte_idx  <= 2'd0;
                end
                default: r_byte_idx <= 2'd0;
              endcase
            end
          end
        endcase
      end else if (r_to_cnt == TO_LIMIT) begin
        // Saturated: abandon any partial frame or packet once.
        if (r_state != ST_IDLE || r_byte_idx != 2'd0) begin
          r_state     <= ST_IDLE;
          r_byte_idx  <= 2'd0;
          o_frame_err <= 1'b1;
        end
      end else begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end
    end
  end

  assign o_dbg_state    = r_state;
  assign o_dbg_byte_idx = r_byte_idx;

endmodule

// File: tb/tb_ps2_mouse_rx.sv
// Directed testbench for ps2_mouse_rx. Drives PS/2 frames on the pins and
// checks cursor position, buttons and strobe counts against hand-computed
// values.

module tb_ps2_mouse_rx;

  localparam int TO   = 2000;  // shortened timeout for simulation
  localparam int HALF = 10;    // clk cycles per PS/2 clock half-period

  // Clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;
  always #5 clk = ~clk;

  logic [11:0] xpos, ypos;
  logic        left, right, middle, pkt_valid, frame_err;
  logic [1:0]  dbg_state, dbg_byte_idx;

  ps2_mouse_rx #(
    .X_MAX(1023),
    .Y_MAX(767),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_ps2_clk(ps2_clk),
    .i_ps2_data(ps2_data),
    .o_xpos(xpos),
    .o_ypos(ypos),
    .o_left(left),
    .o_right(right),
    .o_middle(middle),
    .o_pkt_valid(pkt_valid),
    .o_frame_err(frame_err),
    .o_dbg_state(dbg_state),
    .o_dbg_byte_idx(dbg_byte_idx)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Strobe monitor, sampled away from the active edge
  int pv_cnt = 0;
  int fe_cnt = 0;
  int both_cnt = 0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (pkt_valid) pv_cnt++;
      if (frame_err) fe_cnt++;
      if (pkt_valid && frame_err) both_cnt++;
    end
  end

  // Driver tasks
  task automatic do_reset();
    rst_n = 1'b0;
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
  endtask

  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = bits[i];
      repeat (HALF) @(posedge clk);
      ps2_clk = 1'b0;
      repeat (HALF) @(posedge clk);
      ps2_clk = 1'b1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic bad_par);
    logic par;
    par = ~(^b) ^ bad_par;
    send_bits({1'b1, par, b, 1'b0}, 11);
    repeat (HALF) @(posedge clk);
  endtask

  task automatic settle();
    repeat (10) @(posedge clk);
    @(negedge clk);
  endtask

  // Tests
  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_checks++;
    if (xpos !== 12'd512) begin n_fail++; $display("FAIL reset_xpos: got %0d expected 512", xpos); end
    n_checks++;
    if (ypos !== 12'd384) begin n_fail++; $display("FAIL reset_ypos: got %0d expected 384", ypos); end
    n_checks++;
    if ({left, right, middle, pkt_valid, frame_err} !== 5'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 00000", {left, right, middle, pkt_valid, frame_err});
    end
    n_checks++;
    if ({dbg_state, dbg_byte_idx} !== 4'b0) begin
      n_fail++; $display("FAIL reset_fsm: got %b expected 0000", {dbg_state, dbg_byte_idx});
    end
  endtask

  task automatic test_single_packet();
    int pv0, fe0;
    do_reset();
    pv0 = pv_cnt; fe0 = fe_cnt;
    send_byte(8'h09, 1'b0);
    send_byte(8'h05, 1'b0);
    send_byte(8'h03, 1'b0);
    settle();
    n_checks++;
    if (pv_cnt - pv0 !== 1) begin n_fail++; $display("FAIL single_pv: got %0d expected 1", pv_cnt - pv0); end
    n_checks++;
    if (fe_cnt - fe0 !== 0) begin n_fail++; $display("FAIL single_fe: got %0d expected 0", fe_cnt - fe0); end
    n_checks++;
    if (xpos !== 12'd517) begin n_fail++; $display("FAIL single_xpos: got %0d expected 517", xpos); end
    n_checks++;
    if (ypos !== 12'd381) begin n_fail++; $display("FAIL single_ypos: got %0d expected 381", ypos); end
    n_checks++;
    if ({left, right, middle} !== 3'b100) begin
      n_fail++; $display("FAIL single_btn: got %b expected 100", {left, right, middle});
    end
  endtask

  task automatic test_clamp();
    logic [11:0] exp_x [3];
    logic [11:0] exp_y [3];
    exp_x[0] = 12'd256; exp_x[1] = 12'd0;   exp_x[2] = 12'd0;
    exp_y[0] = 12'd640; exp_y[1] = 12'd767; exp_y[2] = 12'd767;
    do_reset();
    for (int p = 0; p < 3; p++) begin
      send_byte(8'h38, 1'b0);
      send_byte(8'h00, 1'b0);
      send_byte(8'h00, 1'b0);
      settle();
      n_checks++;
      if (xpos !== exp_x[p]) begin n_fail++; $display("FAIL clamp_xpos[%0d]: got %0d expected %0d", p, xpos, exp_x[p]); end
      n_checks++;
      if (ypos !== exp_y[p]) begin n_fail++; $display("FAIL clamp_ypos[%0d]: got %0d expected %0d", p, ypos, exp_y[p]); end
    end
  endtask

  task automatic test_overflow();
    do_reset();
    send_byte(8'h48, 1'b0);
    send_byte(8'h7F, 1'b0);
    send_byte(8'h10, 1'b0);
    settle();
    n_checks++;
    if (xpos !== 12'd512) begin n_fail++; $display("FAIL ovf_xpos: got %0d expected 512", xpos); end
    n_checks++;
    if (ypos !== 12'd368) begin n_fail++; $display("FAIL ovf_ypos: got %0d expected 368", ypos); end
  endtask

  task automatic test_resync();
    int pv0, fe0;
    do_reset();
    pv0 = pv_cnt; fe0 = fe_cnt;
    send_byte(8'h00, 1'b0);
    settle();
    n_checks++;
    if (fe_cnt - fe0 !== 1) begin n_fail++; $display("FAIL resync_fe: got %0d expected 1", fe_cnt - fe0); end
    n_checks++;
    if (dbg_byte_idx !== 2'd0) begin n_fail++; $display("FAIL resync_idx: got %0d expected 0", dbg_byte_idx); end
    send_byte(8'h0A, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    settle();
    n_checks++;
    if (pv_cnt - pv0 !== 1) begin n_fail++; $display("FAIL resync_pv: got %0d expected 1", pv_cnt - pv0); end
    n_checks++;
    if (xpos !== 12'd513) begin n_fail++; $display("FAIL resync_xpos: got %0d expected 513", xpos); end
    n_checks++;
    if ({left, right, middle} !== 3'b010) begin
      n_fail++; $display("FAIL resync_btn: got %b expected 010", {left, right, middle});
    end
  endtask

  task automatic test_timeout();
    int pv0, fe0;
    do_reset();
    pv0 = pv_cnt; fe0 = fe_cnt;
    send_byte(8'h08, 1'b0);
    send_byte(8'h05, 1'b0);
    settle();
    n_checks++;
    if (fe_cnt - fe0 !== 0) begin n_fail++; $display("FAIL timeout_early_fe: got %0d expected 0", fe_cnt - fe0); end
    repeat (TO + 30) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (fe_cnt - fe0 !== 1) begin n_fail++; $display("FAIL timeout_fe: got %0d expected 1", fe_cnt - fe0); end
    n_checks++;
    if (xpos !== 12'd512) begin n_fail++; $display("FAIL timeout_xpos: got %0d expected 512", xpos); end
    send_byte(8'h09, 1'b0);
    send_byte(8'h05, 1'b0);
    send_byte(8'h03, 1'b0);
    settle();
    n_checks++;
    if (pv_cnt - pv0 !== 1) begin n_fail++; $display("FAIL timeout_pv: got %0d expected 1", pv_cnt - pv0); end
    n_checks++;
    if (xpos !== 12'd517 || ypos !== 12'd381) begin
      n_fail++; $display("FAIL timeout_pos: got %0d,%0d expected 517,381", xpos, ypos);
    end
  endtask

  task automatic test_parity();
    int pv0, fe0;
    do_reset();
    pv0 = pv_cnt; fe0 = fe_cnt;
    send_byte(8'h08, 1'b0);
    send_byte(8'h02, 1'b1);
    send_byte(8'h00, 1'b0);
    settle();
`ifdef PS2_PARITY_CHECK_EN
    // Byte 1 is dropped; the following 0x00 then fails the header check.
    n_checks++;
    if (pv_cnt - pv0 !== 0) begin n_fail++; $display("FAIL parity_pv: got %0d expected 0", pv_cnt - pv0); end
    n_checks++;
    if (fe_cnt - fe0 !== 2) begin n_fail++; $display("FAIL parity_fe: got %0d expected 2", fe_cnt - fe0); end
    n_checks++;
    if (xpos !== 12'd512) begin n_fail++; $display("FAIL parity_xpos: got %0d expected 512", xpos); end
`else
    n_checks++;
    if (pv_cnt - pv0 !== 1) begin n_fail++; $display("FAIL parity_pv: got %0d expected 1", pv_cnt - pv0); end
    n_checks++;
    if (fe_cnt - fe0 !== 0) begin n_fail++; $display("FAIL parity_fe: got %0d expected 0", fe_cnt - fe0); end
    n_checks++;
    if (xpos !== 12'd514) begin n_fail++; $display("FAIL parity_xpos: got %0d expected 514", xpos); end
`endif
  endtask

  task automatic test_async_reset();
    do_reset();
    send_byte(8'h09, 1'b0);
    send_byte(8'h05, 1'b0);
    send_byte(8'h03, 1'b0);
    settle();
    // Start a frame: start bit plus three data bits
    send_bits(11'b000_0000_1010, 4);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (xpos !== 12'd512 || ypos !== 12'd384) begin
      n_fail++; $display("FAIL async_rst_pos: got %0d,%0d expected 512,384", xpos, ypos);
    end
    n_checks++;
    if ({left, dbg_state, dbg_byte_idx} !== 5'b0) begin
      n_fail++; $display("FAIL async_rst_state: got %b expected 00000", {left, dbg_state, dbg_byte_idx});
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
  endtask

  initial begin
    test_reset();
    test_single_packet();
    test_clamp();
    test_overflow();
    test_resync();
    test_timeout();
    test_parity();
    test_async_reset();
    n_checks++;
    if (both_cnt !== 0) begin n_fail++; $display("FAIL strobe_overlap: got %0d expected 0", both_cnt); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
